pseudo_spi_sram_rx: RTL and testbench
=====================================

# pseudo_spi_sram_rx

Read-back counterpart of the pseudo-SPI serializer: after a START request it pulses SEL to make the analog device parallel-load its scan chain, generates the two-phase shift clocks SCLK1/SCLK2, deserializes SPI_SI into MEMORY_DATA_WIDTH-bit words and writes them to consecutive SRAM addresses beginning at ADDR_BGN. It sits between the analog device's serial output and the shared SRAM port, on the CPU side of the analog interface.

## Interface
- MEMORY_DATA_WIDTH, 8, bits per SRAM word and per deserialized word
- MEMORY_ADDR_WIDTH, 9, SRAM address width
- RESERVED_DATA_LEN, 8, width of DATA_LEN, which counts words
- CLK  input  1  system clock; all logic on the rising edge
- RST  input  1  reset; asynchronous and active-high
- START  input  1  one-cycle request; sampled only in IDLE
- ADDR_BGN  input  MEMORY_ADDR_WIDTH  first SRAM write address, latched on START
- DATA_LEN  input  RESERVED_DATA_LEN  number of words to capture, latched on START
- SPI_SI  input  1  serial data from the analog device
- SCLK1  output  1  shift clock phase 1
- SCLK2  output  1  shift clock phase 2
- SEL  output  1  scan-chain parallel-load select to the analog device
- A  output  MEMORY_ADDR_WIDTH  SRAM address
- PO  output  MEMORY_DATA_WIDTH  SRAM write data
- CEN  output  1  SRAM chip enable, active-low
- D_WE  output  1  SRAM write enable, active-low (0 means write)
- BUSY  output  1  high in every state except IDLE
- DONE  output  1  one-cycle completion pulse

## Operation
- States: IDLE, SELECT, SHIFT, WRITE, DONE.
- IDLE, START=1, DATA_LEN≠0: latch ADDR_BGN into the address register and DATA_LEN into the word counter, then go to SELECT.
- IDLE, START=1, DATA_LEN=0: go straight to DONE. No SEL, no clocks, no writes.
- SELECT: hold SEL=1 for exactly 2 cycles, then go to SHIFT with phase=0 and bit=0.
- SHIFT: each bit occupies a 4-cycle slot, phase 0..3.
  - Phase 0: SPI_SI is sampled on the closing edge into bit position `bit`. Default order is LSB first.
  - Phase 1: SCLK1=1.
  - Phase 2: both clocks low (non-overlap gap).
  - Phase 3: SCLK2=1.
  - After phase 3 of bit MEMORY_DATA_WIDTH-1, go to WRITE.
- WRITE (1 cycle): CEN=0, D_WE=0, A = address register, PO = assembled word. On exit:
  - address increments by 1, wrapping modulo 2^MEMORY_ADDR_WIDTH;
  - word counter decrements;
  - counter still nonzero: back to SHIFT (phase 0, bit 0, no new SEL);
  - counter zero: go to DONE.
- DONE (1 cycle): DONE=1, then IDLE.
- START outside IDLE is ignored. ADDR_BGN and DATA_LEN changes after latching have no effect.
- Outside WRITE: CEN=1, D_WE=1, and A/PO hold their last value.

## Timing
- Every output comes directly from a flop: no combinational decode to pins, no glitches on SCLK1/SCLK2/SEL.
- SCLK1 and SCLK2 are never high in the same cycle and are always separated by at least one low cycle.
- START sampled at edge 0:
  - SEL is high in cycles 1–2;
  - the first SHIFT phase 0 is cycle 3;
  - the first WRITE is cycle 3 + 4·MEMORY_DATA_WIDTH.
- Per word: 4·MEMORY_DATA_WIDTH + 1 cycles.
- Total from START edge to the DONE cycle: 3 + DATA_LEN·(4·MEMORY_DATA_WIDTH + 1) cycles. This is 36 for one 8-bit word.
- The analog device must present the next bit on SPI_SI by the next phase 0 after SCLK2 falls. The first bit must be valid after SEL deasserts.
- Reset values, applied immediately on RST=1:
  - state IDLE, SCLK1=0, SCLK2=0, SEL=0;
  - CEN=1, D_WE=1;
  - A=0, PO=0;
  - BUSY=0, DONE=0;
  - internal counters 0.
- RST mid-transfer aborts at once: no further write, and any partially assembled word is discarded.

## Configuration
- PSEUDO_SPI_RX_MSB_FIRST_EN:
  - defined: the first sampled bit goes into PO[MEMORY_DATA_WIDTH-1], descending;
  - undefined: the first sampled bit goes into PO[0], ascending, matching the serializer's LSB-first order.
- Cycle timing is identical in both builds.

## Structure
- The shared package holds:
  - state encodings (IDLE/SELECT/SHIFT/WRITE/DONE);
  - SEL_CYCLES=2 and SLOT_CYCLES=4;
  - phase indices for sample, SCLK1 and SCLK2.
- One sub-module, pseudo_spi_phase_gen:
  - 2-bit phase counter enabled in SHIFT;
  - produces registered SCLK1/SCLK2, a sample strobe and an end-of-slot strobe.
- The top level holds the FSM, bit/word/address counters and the deserializer register.

## Test plan
- ADDR_BGN=0x010, DATA_LEN=1, SPI_SI bits 1,0,1,1,0,0,1,0 (first to last) -> one write at A=0x010 with PO=0x4D (MSB_FIRST_EN build: 0xB2); DONE at cycle 36; exactly 8 SCLK1 and 8 SCLK2 pulses.
- ADDR_BGN=0x1FE, DATA_LEN=3, words 0x11,0x22,0x33 -> writes at 0x1FE, 0x1FF, 0x000; a single 2-cycle SEL pulse; DONE at cycle 102.
- DATA_LEN=0 with START -> DONE at cycle 1; no SEL, SCLK or CEN activity.
- START pulsed again mid-transfer, with ADDR_BGN changed -> ignored; the original address sequence and DONE timing are unchanged.
- RST asserted during SHIFT of word 2 of 4 -> all outputs at reset values in that cycle; no further CEN low; a new START runs a clean transfer.
- Every cycle of a random-length run -> never SCLK1&SCLK2, never CEN=0 outside WRITE, and SCLK1/SCLK2/SEL/CEN/D_WE glitch-free.

Source files
------------

// File: rtl/pseudo_spi_sram_rx_pkg.sv
// rtl/pseudo_spi_sram_rx_pkg.sv - shared widths, state encoding and shift-slot constants
package pseudo_spi_sram_rx_pkg;
  localparam int MEMORY_DATA_WIDTH = 8;
  localparam int MEMORY_ADDR_WIDTH = 9;
  localparam int RESERVED_DATA_LEN = 8;
  localparam int BIT_W             = $clog2(MEMORY_DATA_WIDTH);

  localparam int SEL_CYCLES  = 2;
  localparam int SLOT_CYCLES = 4;

  localparam logic [1:0]       PH_SAMPLE = 2'd0;
  localparam logic [1:0]       PH_SCLK1  = 2'd1;
  localparam logic [1:0]       PH_SCLK2  = 2'd3;
  localparam logic [1:0]       PH_LAST   = 2'(SLOT_CYCLES - 1);
  localparam logic [1:0]       SEL_LAST  = 2'(SEL_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(MEMORY_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SHIFT,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Word bit position that receives the n-th serial bit of a word.
  function automatic logic [BIT_W-1:0] bit_index(input logic [BIT_W-1:0] b);
`ifdef PSEUDO_SPI_RX_MSB_FIRST_EN
    return BIT_LAST - b;
`else
    return b;
`endif
  endfunction
endpackage

// File: rtl/pseudo_spi_sram_rx_if.sv
// rtl/pseudo_spi_sram_rx_if.sv - request, serial and SRAM-port signals of the read-back engine
interface pseudo_spi_sram_rx_if;
  import pseudo_spi_sram_rx_pkg::*;

  logic                         START;
  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN;
  logic [RESERVED_DATA_LEN-1:0] DATA_LEN;
  logic                         SPI_SI;
  logic                         SCLK1;
  logic                         SCLK2;
  logic                         SEL;
  logic [MEMORY_ADDR_WIDTH-1:0] A;
  logic [MEMORY_DATA_WIDTH-1:0] PO;
  logic                         CEN;
  logic                         D_WE;
  logic                         BUSY;
  logic                         DONE;

  modport master (
    output START, ADDR_BGN, DATA_LEN, SPI_SI,
    input  SCLK1, SCLK2, SEL, A, PO, CEN, D_WE, BUSY, DONE
  );

  modport slave (
    input  START, ADDR_BGN, DATA_LEN, SPI_SI,
    output SCLK1, SCLK2, SEL, A, PO, CEN, D_WE, BUSY, DONE
  );
endinterface

// File: rtl/pseudo_spi_phase_gen.sv
// rtl/pseudo_spi_phase_gen.sv - 4-phase bit slot counter with registered two-phase shift clocks
module pseudo_spi_phase_gen
  import pseudo_spi_sram_rx_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic SCLK1,
  output logic SCLK2,
  output logic sample,
  output logic slot_end
);
  logic [1:0] phase;
  logic [1:0] phase_inc;

  assign phase_inc = phase + 2'd1;
  assign sample    = en && (phase == PH_SAMPLE);
  assign slot_end  = en && (phase == PH_LAST);

  // Clocks are registered from the phase about to be entered so pins come straight off flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase <= 2'd0;
      SCLK1 <= 1'b0;
      SCLK2 <= 1'b0;
    end else begin
      phase <= en ? phase_inc : 2'd0;
      SCLK1 <= en && (phase_inc == PH_SCLK1);
      SCLK2 <= en && (phase_inc == PH_SCLK2);
    end
  end
endmodule

// File: rtl/pseudo_spi_sram_rx.sv
// rtl/pseudo_spi_sram_rx.sv - scan-chain read-back deserializer into SRAM; PSEUDO_SPI_RX_MSB_FIRST_EN selects MSB-first
module pseudo_spi_sram_rx
  import pseudo_spi_sram_rx_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  pseudo_spi_sram_rx_if.slave  bus
);
  state_t                       state;
  state_t                       state_nxt;
  logic [1:0]                   sel_cnt;
  logic [BIT_W-1:0]             bit_cnt;
  logic [RESERVED_DATA_LEN-1:0] word_cnt;
  logic [MEMORY_ADDR_WIDTH-1:0] addr;
  logic [MEMORY_DATA_WIDTH-1:0] shreg;
  logic                         shift_en;
  logic                         sample;
  logic                         slot_end;
  logic                         sclk1;
  logic                         sclk2;

  assign shift_en  = (state == ST_SHIFT);
  assign bus.SCLK1 = sclk1;
  assign bus.SCLK2 = sclk2;

  pseudo_spi_phase_gen u_phase_gen (
    .CLK      (CLK),
    .RST      (RST),
    .en       (shift_en),
    .SCLK1    (sclk1),
    .SCLK2    (sclk2),
    .sample   (sample),
    .slot_end (slot_end)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.START) state_nxt = (bus.DATA_LEN == '0) ? ST_DONE : ST_SELECT;
      ST_SELECT: if (sel_cnt == SEL_LAST) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (slot_end && bit_cnt == BIT_LAST) state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = (word_cnt == RESERVED_DATA_LEN'(1)) ? ST_DONE : ST_SHIFT;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Pin registers load from the next state, so each pin toggles exactly with the state it reflects.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_cnt  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      addr     <= '0;
      shreg    <= '0;
      bus.SEL  <= 1'b0;
      bus.CEN  <= 1'b1;
      bus.D_WE <= 1'b1;
      bus.A    <= '0;
      bus.PO   <= '0;
      bus.BUSY <= 1'b0;
      bus.DONE <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sel_cnt <= '0;
          bit_cnt <= '0;
          if (bus.START && bus.DATA_LEN != '0) begin
            addr     <= bus.ADDR_BGN;
            word_cnt <= bus.DATA_LEN;
          end
        end
        ST_SELECT: sel_cnt <= sel_cnt + 2'd1;
        ST_SHIFT: begin
          if (sample) shreg[bit_index(bit_cnt)] <= bus.SPI_SI;
          if (slot_end) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
        ST_WRITE: begin
          addr     <= addr + 1'b1;
          word_cnt <= word_cnt - 1'b1;
        end
        default: ;
      endcase

      bus.SEL  <= (state_nxt == ST_SELECT);
      bus.CEN  <= (state_nxt != ST_WRITE);
      bus.D_WE <= (state_nxt != ST_WRITE);
      bus.BUSY <= (state_nxt != ST_IDLE);
      bus.DONE <= (state_nxt == ST_DONE);
      if (state_nxt == ST_WRITE) begin
        bus.A  <= addr;
        bus.PO <= shreg;
      end
    end
  end
endmodule

// File: tb/tb_pseudo_spi_sram_rx.sv
// tb/tb_pseudo_spi_sram_rx.sv - scoreboard bench for the scan-chain read-back deserializer
module tb_pseudo_spi_sram_rx;
  import pseudo_spi_sram_rx_pkg::*;

  typedef struct {
    logic [MEMORY_ADDR_WIDTH-1:0] a;
    logic [MEMORY_DATA_WIDTH-1:0] d;
  } wr_t;

  typedef struct {
    int cycle;
    int s1;
    int s2;
    int sel;
  } done_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pseudo_spi_sram_rx_if bus ();
  pseudo_spi_sram_rx dut (.CLK(CLK), .RST(RST), .bus(bus));

  wr_t   exp_wr[$];
  done_t exp_done[$];
  bit    bitq[$];
  int    checks = 0;
  int    errors = 0;
  int    edge_cnt = 0;
  int    start_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) edge_cnt++;

  // Analog device model: next bit appears after SEL falls and after each SCLK2 falls.
  logic d_sel = 1'b0, d_s2 = 1'b0;
  always @(negedge CLK) begin
    if (RST) begin
      d_sel = 1'b0;
      d_s2  = 1'b0;
    end else begin
      if ((d_sel && !bus.SEL) || (d_s2 && !bus.SCLK2))
        bus.SPI_SI = (bitq.size() != 0) ? bitq.pop_front() : 1'b0;
      d_sel = bus.SEL;
      d_s2  = bus.SCLK2;
    end
  end

  // Monitor: pops expected writes/completions whenever the DUT presents one.
  logic  p_s1 = 1'b0, p_s2 = 1'b0, p_cen = 1'b1;
  int    n_s1 = 0, n_s2 = 0, n_sel = 0;
  wr_t   w;
  done_t d;
  always @(negedge CLK) begin
    if (RST) begin
      p_s1 = 1'b0; p_s2 = 1'b0; p_cen = 1'b1;
      n_s1 = 0; n_s2 = 0; n_sel = 0;
    end else begin
      if (bus.SCLK1 && !p_s1) n_s1++;
      if (bus.SCLK2 && !p_s2) n_s2++;
      if (bus.SEL) n_sel++;
      check("sclk_overlap", 32'(bus.SCLK1 & bus.SCLK2), 0);
      check("sclk_gap", 32'((bus.SCLK1 & p_s2) | (bus.SCLK2 & p_s1)), 0);
      if (!bus.CEN) begin
        check("we_with_cen", 32'(bus.D_WE), 0);
        check("cen_one_cycle", 32'(p_cen), 1);
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 32'(bus.A), 32'hFFFF_FFFF);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(bus.A), 32'(w.a));
          check("wr_data", 32'(bus.PO), 32'(w.d));
        end
      end
      if (bus.DONE) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 32'(edge_cnt - start_edge + 1), 32'hFFFF_FFFF);
        end else begin
          d = exp_done.pop_front();
          check("done_cycle", 32'(edge_cnt - start_edge + 1), 32'(d.cycle));
          check("sclk1_pulses", 32'(n_s1), 32'(d.s1));
          check("sclk2_pulses", 32'(n_s2), 32'(d.s2));
          check("sel_cycles", 32'(n_sel), 32'(d.sel));
          check("busy_at_done", 32'(bus.BUSY), 1);
        end
        n_s1 = 0; n_s2 = 0; n_sel = 0;
      end
      p_s1  = bus.SCLK1;
      p_s2  = bus.SCLK2;
      p_cen = bus.CEN;
    end
  end

  task automatic push_word(input logic [7:0] wd);
    for (int i = 0; i < 8; i++) begin
`ifdef PSEUDO_SPI_RX_MSB_FIRST_EN
      bitq.push_back(wd[7-i]);
`else
      bitq.push_back(wd[i]);
`endif
    end
  endtask

  task automatic start(input logic [MEMORY_ADDR_WIDTH-1:0] a, input logic [RESERVED_DATA_LEN-1:0] len);
    @(negedge CLK);
    #1;
    bus.ADDR_BGN = a;
    bus.DATA_LEN = len;
    start_edge   = edge_cnt + 1;
    bus.START    = 1'b1;
    @(negedge CLK);
    #1;
    bus.START    = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_done.size() != 0 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (exp_done.size() != 0) begin
      check("done_timeout", 32'(exp_done.size()), 0);
      exp_done.delete();
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk1"}, 32'(bus.SCLK1), 0);
    check({tag, "_sclk2"}, 32'(bus.SCLK2), 0);
    check({tag, "_sel"},   32'(bus.SEL), 0);
    check({tag, "_cen"},   32'(bus.CEN), 1);
    check({tag, "_d_we"},  32'(bus.D_WE), 1);
    check({tag, "_a"},     32'(bus.A), 0);
    check({tag, "_po"},    32'(bus.PO), 0);
    check({tag, "_busy"},  32'(bus.BUSY), 0);
    check({tag, "_done"},  32'(bus.DONE), 0);
  endtask

  initial begin
    bus.START    = 1'b0;
    bus.ADDR_BGN = '0;
    bus.DATA_LEN = '0;
    bus.SPI_SI   = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    #1 RST = 1'b0;
    repeat (2) @(negedge CLK);

    // One word, bits 1,0,1,1,0,0,1,0 first to last.
    bitq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef PSEUDO_SPI_RX_MSB_FIRST_EN
    exp_wr.push_back('{9'h010, 8'hB2});
`else
    exp_wr.push_back('{9'h010, 8'h4D});
`endif
    exp_done.push_back('{36, 8, 8, 2});
    start(9'h010, 8'd1);
    wait_done();

    // Address wrap across three words.
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    exp_wr.push_back('{9'h1FE, 8'h11});
    exp_wr.push_back('{9'h1FF, 8'h22});
    exp_wr.push_back('{9'h000, 8'h33});
    exp_done.push_back('{102, 24, 24, 2});
    start(9'h1FE, 8'd3);
    wait_done();

    // Zero-length request completes immediately.
    exp_done.push_back('{1, 0, 0, 0});
    start(9'h055, 8'd0);
    wait_done();

    // START mid-transfer with new address/length is ignored.
    push_word(8'hA5); push_word(8'h3C);
    exp_wr.push_back('{9'h050, 8'hA5});
    exp_wr.push_back('{9'h051, 8'h3C});
    exp_done.push_back('{69, 16, 16, 2});
    start(9'h050, 8'd2);
    repeat (20) @(negedge CLK);
    #1;
    bus.ADDR_BGN = 9'h100;
    bus.DATA_LEN = 8'd5;
    bus.START    = 1'b1;
    @(negedge CLK);
    #1 bus.START = 1'b0;
    wait_done();

    // Reset during the second word of four: only the first write may appear.
    push_word(8'h01); push_word(8'h02); push_word(8'h03); push_word(8'h04);
    exp_wr.push_back('{9'h0A0, 8'h01});
    start(9'h0A0, 8'd4);
    repeat (50) @(negedge CLK);
    #2 RST = 1'b1;
    #1 check_reset_outputs("abort");
    bitq.delete();
    bus.SPI_SI = 1'b0;
    repeat (2) @(negedge CLK);
    check("abort_writes_seen", 32'(exp_wr.size()), 0);
    #1 RST = 1'b0;
    repeat (40) @(negedge CLK);

    // Clean transfer after the abort.
    push_word(8'h5A);
    exp_wr.push_back('{9'h0A0, 8'h5A});
    exp_done.push_back('{36, 8, 8, 2});
    start(9'h0A0, 8'd1);
    wait_done();

    check("writes_drained", 32'(exp_wr.size()), 0);
    check("idle_busy", 32'(bus.BUSY), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
